if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction fetch queue between pc_reg and the IF/ID boundary of the 5-stage MIPS pipeline.
- Each cycle with ce high, it captures the {pc, instruction} pair presented by pc_reg and the combinational instruction ROM, and buffers up to DEPTH pairs.
- It presents the oldest pair to decode.
- Drives bbl back to pc_reg so the PC holds while the queue is full, and decouples decode stalls from fetch.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- pc_i  input  32  fetch address from pc_reg
- ce_i  input  1  chip enable from pc_reg; 1 = pc_i/inst_i are valid
- inst_i  input  32  instruction word from ROM for address pc_i, same cycle
- stall_i  input  1  decode stall; 1 = decode does not consume the head entry this cycle
- flush_i  input  1  discard all queued and incoming entries this cycle
- bbl_o  output  1  backpressure to pc_reg; 1 = hold PC (BblEnable)
- id_pc_o  output  32  PC of the head entry
- id_inst_o  output  32  instruction of the head entry
- id_valid_o  output  1  head entry valid
- count_o  output  PTR_W+1  number of stored entries, 0..DEPTH

Behaviour:
- Reset is the Already-decided control: reset rst, synchronous, active-high; clock clk.
- On rst=1 at a rising edge:
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs after reset: bbl_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0.
  - Entry storage is not cleared.
  - Reset mid-operation drops all entries.
- bbl_o = (count == DEPTH). Purely a function of registered count, so there is no combinational path from stall_i.
- push = ce_i & ~bbl_o & ~flush_i. pc_reg advances exactly when the pair is accepted, so no address is lost or duplicated.
- pop = id_valid_o & ~stall_i & ~flush_i.
- Push writes {pc_i, inst_i} at wr_ptr, then wr_ptr increments modulo DEPTH. Pop increments rd_ptr modulo DEPTH. Pointer wrap-around is natural binary overflow.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop
- Head outputs:
  - When count>0: id_valid_o=1, and id_pc_o/id_inst_o = storage[rd_ptr], read combinationally from registered storage.
  - When count=0: id_valid_o=0, id_pc_o=0, id_inst_o=0 (NOP to decode).
- Latency: a pair accepted at edge N is visible on the head outputs after edge N when the queue was empty. Fetch-to-decode latency is 1 cycle.
- Full (count=DEPTH) with pop: the pop proceeds and no push is accepted. bbl_o deasserts in the next cycle.
- Empty with stall_i=1: nothing happens; a push is still accepted.
- flush_i=1 (highest priority after rst):
  - At the edge: count=0 and rd_ptr=wr_ptr=0.
  - The incoming pair that cycle is discarded, and bbl_o remains per the current count.
  - Flush together with a decode stall still empties the queue.
- ce_i=0 (pc_reg in reset): no push.

Optional Feature:
- Macro: IF_FETCH_BYPASS_EN.
- Defined: when count=0 and ce_i=1, head outputs pass through combinationally, giving 0-cycle latency:
  - id_valid_o=1, id_pc_o=pc_i, id_inst_o=inst_i.
  - Also requires bbl_o=0 and flush_i=0.
  - If stall_i=0, the pair is consumed directly and not stored; count stays 0.
  - If stall_i=1, the pair is stored as normal.
- Undefined: no bypass; behaviour exactly as above.

Test Plan:
- Reset then stream: rst for 2 cycles, then ce_i=1, pc_i=0,4,8 with inst_i=0x34010001.., stall_i=0 -> id_valid_o rises one cycle after the first push; id_pc_o follows 0,4,8; count_o stays 1; bbl_o=0 throughout.
- Fill to full: DEPTH=4, stall_i=1, pc 0..0xC pushed -> count_o=4 and bbl_o=1 after the 4th edge; pc_i held at 0x10 not pushed while bbl_o=1; id_pc_o=0.
- Drain from full: from the full state, release stall_i -> one pop per cycle; bbl_o=0 the cycle after the first pop; 0x10 is accepted once only; head order 0,4,8,0xC,0x10 with no duplicates.
- Wrap-around: 10 pushes with alternating stall -> pointers wrap; head PCs are strictly increasing by 4; count_o never exceeds 4.
- Flush: queue holding 3 entries, flush_i=1 with ce_i=1 and pc_i=0x20 -> next cycle count_o=0, id_valid_o=0, 0x20 is not delivered; the next push at 0x24 appears as head.
- Mid-operation reset and bypass: rst at count_o=3 -> all outputs 0 next cycle. With IF_FETCH_BYPASS_EN, empty queue, pc_i=0x40, stall_i=0 -> id_valid_o=1 and id_pc_o=0x40 in the same cycle, and count_o stays 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between pc_reg and IF/ID: buffers {pc, inst} pairs and holds the PC via bbl_o when full.
// Optional IF_FETCH_BYPASS_EN: an empty queue passes the incoming pair straight to decode (0-cycle latency).
module if_fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_i,
  input  logic             ce_i,
  input  logic [31:0]      inst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             bbl_o,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_inst_o,
  output logic             id_valid_o,
  output logic [PTR_W:0]   count_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_head_vld;
  logic w_byp;
  logic w_push;
  logic w_pop;
  ent_t w_head;

  // bbl_o comes only from registered count, so decode stalls never reach pc_reg combinationally.
  assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign w_head_vld = (r_count != '0);

`ifdef IF_FETCH_BYPASS_EN
  assign w_byp = ~w_head_vld & ce_i & ~flush_i;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed pair that decode takes this cycle is never written into storage.
  assign w_push = ce_i & ~w_full & ~flush_i & ~(w_byp & ~stall_i);
  assign w_pop  = w_head_vld & ~stall_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left uncleared on reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= {pc_i, inst_i};
  end

  always_comb begin
    w_head = '0;
    if (w_head_vld)  w_head = r_mem[r_rd_ptr];
    else if (w_byp)  w_head = {pc_i, inst_i};
  end

  assign bbl_o      = w_full;
  assign id_valid_o = w_head_vld | w_byp;
  assign id_pc_o    = w_head.pc;
  assign id_inst_o  = w_head.inst;
  assign count_o    = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, ce_i, stall_i, flush_i;
  logic [31:0] pc_i, inst_i;
  logic        bbl_o, id_valid_o;
  logic [31:0] id_pc_o, id_inst_o;
  logic [2:0]  count_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .inst_i(inst_i),
    .stall_i(stall_i), .flush_i(flush_i), .bbl_o(bbl_o),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o),
    .count_o(count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of {pc, inst} pairs plus a log of every pc handed to decode.
  logic [63:0] mq[$];
  logic [31:0] delivered[$];
  bit          chk_en = 1'b0;

  function automatic bit m_byp();
`ifdef IF_FETCH_BYPASS_EN
    return (mq.size() == 0) && ce_i && !flush_i;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit full, byp, push, pop;
    if (rst) begin
      mq.delete();
      chk_en = 1'b1;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      full = (mq.size() == DEPTH);
      byp  = m_byp();
      pop  = (mq.size() > 0) && !stall_i;
      push = ce_i && !full && !(byp && !stall_i);
      if (byp && !stall_i) delivered.push_back(pc_i);
      if (pop) begin
        delivered.push_back(mq[0][63:32]);
        mq.delete(0);
      end
      if (push) mq.push_back({pc_i, inst_i});
    end
  end

  always @(negedge clk) begin
    logic        ev;
    logic [63:0] eh;
    if (chk_en) begin
      ev = 1'b0;
      eh = '0;
      if (mq.size() > 0) begin
        ev = 1'b1;
        eh = mq[0];
      end else if (m_byp()) begin
        ev = 1'b1;
        eh = {pc_i, inst_i};
      end
      check("m_valid", 32'(id_valid_o), 32'(ev));
      check("m_pc",    id_pc_o,   eh[63:32]);
      check("m_inst",  id_inst_o, eh[31:0]);
      check("m_count", 32'(count_o), 32'(mq.size()));
      check("m_bbl",   32'(bbl_o), 32'(mq.size() == DEPTH));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Acts like pc_reg: the address advances only when the pair was accepted.
  task automatic fetch_cyc();
    bit acc;
    acc = ce_i && !bbl_o && !flush_i;
    cyc();
    if (acc) begin
      pc_i   = pc_i + 32'd4;
      inst_i = inst_i + 32'd1;
    end
  endtask

  initial begin
    int max_cnt;
    rst = 1'b1; ce_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    pc_i = '0; inst_i = '0;
    cyc(); cyc();
    check("rst_count", 32'(count_o), 0);
    check("rst_valid", 32'(id_valid_o), 0);
    check("rst_bbl",   32'(bbl_o), 0);
    check("rst_pc",    id_pc_o, 0);
    check("rst_inst",  id_inst_o, 0);
    rst = 1'b0;

    // stream with no stall
    ce_i = 1'b1; pc_i = 32'h0; inst_i = 32'h34010001;
    fetch_cyc();
`ifndef IF_FETCH_BYPASS_EN
    check("stream_valid1", 32'(id_valid_o), 1);
    check("stream_pc1",    id_pc_o, 32'h0);
    check("stream_inst1",  id_inst_o, 32'h34010001);
    check("stream_cnt1",   32'(count_o), 1);
`else
    check("stream_byp_pc1", id_pc_o, 32'h4);
    check("stream_byp_cnt", 32'(count_o), 0);
`endif
    fetch_cyc(); fetch_cyc();
`ifndef IF_FETCH_BYPASS_EN
    check("stream_pc3",  id_pc_o, 32'h8);
    check("stream_cnt3", 32'(count_o), 1);
`endif
    check("stream_bbl", 32'(bbl_o), 0);
    ce_i = 1'b0;
    cyc();
    check("stream_empty_cnt",   32'(count_o), 0);
    check("stream_empty_valid", 32'(id_valid_o), 0);

    // fill to full while decode stalls
    stall_i = 1'b1; ce_i = 1'b1; pc_i = 32'h0; inst_i = 32'h100;
    repeat (4) fetch_cyc();
    check("fill_cnt", 32'(count_o), 4);
    check("fill_bbl", 32'(bbl_o), 1);
    check("fill_pc",  id_pc_o, 32'h0);
    fetch_cyc(); fetch_cyc();
    check("fill_hold_cnt", 32'(count_o), 4);
    check("fill_hold_pc",  id_pc_o, 32'h0);

    // drain from full
    delivered.delete();
    stall_i = 1'b0;
    fetch_cyc();
    check("drain_bbl", 32'(bbl_o), 0);
    check("drain_cnt", 32'(count_o), 3);
    for (int i = 0; i < 6; i++) begin
      ce_i = (pc_i < 32'h14);
      fetch_cyc();
    end
    check("drain_n", 32'(delivered.size()), 5);
    for (int k = 0; k < delivered.size() && k < 5; k++)
      check("drain_order", delivered[k], 32'(4 * k));

    // wrap-around with alternating stall
    delivered.delete();
    max_cnt = 0;
    pc_i = 32'h100; ce_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      stall_i = i[0];
      ce_i    = (pc_i < 32'h128);
      fetch_cyc();
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    end
    stall_i = 1'b0; ce_i = 1'b0;
    repeat (5) cyc();
    check("wrap_max_cnt_ok", 32'(max_cnt <= DEPTH), 1);
    check("wrap_n", 32'(delivered.size()), 10);
    for (int k = 0; k < delivered.size() && k < 10; k++)
      check("wrap_order", delivered[k], 32'h100 + 32'(4 * k));

    // flush with three entries queued
    stall_i = 1'b1; ce_i = 1'b1; pc_i = 32'h14; inst_i = 32'h200;
    repeat (3) fetch_cyc();
    check("flush_pre_cnt", 32'(count_o), 3);
    check("flush_pre_pc",  pc_i, 32'h20);
    flush_i = 1'b1;
    cyc();
    check("flush_cnt",   32'(count_o), 0);
    check("flush_valid", 32'(id_valid_o), 0);
    check("flush_bbl",   32'(bbl_o), 0);
    flush_i = 1'b0; stall_i = 1'b0;
    delivered.delete();
    pc_i = 32'h24;
    cyc();
    check("flush_next_valid", 32'(id_valid_o), 1);
    check("flush_next_pc",    id_pc_o, 32'h24);
    ce_i = 1'b0;
    cyc(); cyc();
    check("flush_deliv_n", 32'(delivered.size()), 1);
    if (delivered.size() > 0) check("flush_deliv_pc", delivered[0], 32'h24);

    // reset mid-operation
    stall_i = 1'b1; ce_i = 1'b1; pc_i = 32'h30; inst_i = 32'h300;
    repeat (3) fetch_cyc();
    check("mrst_pre_cnt", 32'(count_o), 3);
    rst = 1'b1; ce_i = 1'b0;
    cyc();
    check("mrst_cnt",   32'(count_o), 0);
    check("mrst_valid", 32'(id_valid_o), 0);
    check("mrst_bbl",   32'(bbl_o), 0);
    check("mrst_pc",    id_pc_o, 0);
    check("mrst_inst",  id_inst_o, 0);
    rst = 1'b0; stall_i = 1'b0;
    cyc();

`ifdef IF_FETCH_BYPASS_EN
    ce_i = 1'b1; pc_i = 32'h40; inst_i = 32'h12345678;
    #1;
    check("byp_valid", 32'(id_valid_o), 1);
    check("byp_pc",    id_pc_o, 32'h40);
    check("byp_inst",  id_inst_o, 32'h12345678);
    check("byp_cnt0",  32'(count_o), 0);
    cyc();
    ce_i = 1'b0;
    check("byp_cnt1",  32'(count_o), 0);
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
